prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Bit-serial program loader; the write side of the core's instruction memory.
//  - Receives 32-bit instruction words on two ui_in pins (ser_clk, ser_data) and writes them to sequential instruction-memory addresses.
//  - Holds the single-cycle core in reset while loading; releases it when the load ends.
//  - Sits between the top-level pins and the instruction memory write port. The core's fetch path is the reader of that memory.
// PARAMETERS
//  ADDR_W       5   instruction-memory address width; capacity is 2**ADDR_W words
//  DATA_W       32  instruction word width (bits shifted per word)
//  SYNC_STAGES  2   synchroniser flops on ser_clk and ser_data (minimum 2)
// PORTS
//  clk         in   1         system clock; all logic on posedge
//  rst_n       in   1         synchronous reset, active low
//  load_en     in   1         level; 1 = loader mode requested
//  ser_clk     in   1         async serial clock from pin; data sampled on its rising edge
//  ser_data    in   1         async serial data from pin, MSB first
//  imem_we     out  1         one-cycle write strobe to instruction memory
//  imem_addr   out  ADDR_W    write address; valid while imem_we=1
//  imem_wdata  out  DATA_W    write data; valid while imem_we=1
//  cpu_rst_n   out  1         core reset, active low; 0 while loading
//  busy        out  1         1 in SHIFT or WRITE
//  done        out  1         1 in DONE
//  full        out  1         sticky; set after the word at address 2**ADDR_W-1 is written
//  word_cnt    out  ADDR_W+1  words written since the load started
//  checksum    out  DATA_W    XOR of all words written (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge), reset values:
//    - state=IDLE; imem_we=0; imem_addr=0; imem_wdata=0.
//    - busy=0; done=0; full=0; word_cnt=0; checksum=0.
//    - Synchroniser flops=0; bit counter=0.
//    - cpu_rst_n=0 during reset.
//  - Input sampling:
//    - ser_clk and ser_data each pass through SYNC_STAGES flops.
//    - A rising edge is synced ser_clk =1 while its previous-cycle value was 0.
//    - On that cycle, synced ser_data shifts into the LSB of the shift register. The existing bits move toward the MSB, so the first bit received ends up as the MSB.
//    - Host must keep ser_clk high and low for at least SYNC_STAGES+2 clk cycles each.
//  - FSM:
//    - IDLE: cpu_rst_n=1. On load_en=1: clear word_cnt, full, checksum and the bit counter; go to SHIFT.
//    - SHIFT: cpu_rst_n=0. Each ser_clk edge shifts one bit and increments the bit counter.
//      - On the DATA_W-th bit: go to WRITE if full=0. If full=1, discard the word and stay in SHIFT.
//    - WRITE (exactly 1 cycle):
//      - imem_we=1; imem_addr=word_cnt[ADDR_W-1:0]; imem_wdata=shift register.
//      - Next cycle: word_cnt+1; checksum^=word; bit counter=0.
//      - If word_cnt was 2**ADDR_W-1, set full.
//      - Return to SHIFT.
//    - DONE: cpu_rst_n=1; done=1. The count and checksum registers hold their final values. On load_en=1, restart exactly as from IDLE.
//  - load_en=0 seen in SHIFT goes to DONE. Any partial word is discarded; no write.
//  - load_en=0 during WRITE: the write still completes, then go to DONE.
//  - A ser_clk edge in the WRITE cycle is captured as bit 0 of the next word. No bit is lost.
//  - The address never wraps. Once full=1, no further imem_we pulses occur in that load session.
//  - Latency: pin edge of the last bit to imem_we = SYNC_STAGES+1 clk cycles.
//  - rst_n=0 mid-load: immediate reset to IDLE values; no write is issued.
// CONFIGURATION
//  - Macro LOADER_CHECKSUM_EN:
//    - Defined: checksum accumulates the XOR of every word written. It is cleared at load start and held in DONE.
//    - Undefined: no checksum register is built; checksum is tied to 0.
// TESTING
//  1. Reset with rst_n=0 for 2 cycles, load_en=1 -> all outputs at reset values; no imem_we.
//  2. load_en=1, shift 0x00500093, then load_en=0 -> one imem_we pulse, addr=0, wdata=0x00500093; word_cnt=1; done=1; cpu_rst_n=1.
//  3. Shift 33 words 0..32 -> addr 0..31 written in order; full=1 after the 32nd write; 33rd word gives no imem_we; word_cnt=32.
//  4. Shift 17 bits, then load_en=0 -> no imem_we; state DONE; word_cnt=0; cpu_rst_n=1.
//  5. rst_n=0 after 20 bits of word 2 -> no write; outputs at reset values. A new load then writes addr 0.
//  6. Shift 0xFFFF0000 and 0x0F0F0F0F -> checksum=0xF0F00F0F with LOADER_CHECKSUM_EN; 0x00000000 without.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: bit-serial program loader that writes the core's instruction memory.
// Two async pins (ser_clk, ser_data) are synchronised. Each rising ser_clk edge
// shifts one bit in, MSB first. Every DATA_W bits one word is written to the next
// instruction-memory address. The core is held in reset for the whole load session.
// Optional feature: define LOADER_CHECKSUM_EN to build the XOR checksum of the
// written words. When it is undefined, checksum is tied to 0.
module prog_loader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              ser_clk,
  input  logic              ser_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   word_cnt,
  output logic [DATA_W-1:0] checksum
);

  localparam int BCNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic [DATA_W-1:0]      r_shift;
  logic [BCNT_W-1:0]      r_bit_cnt;
  logic [ADDR_W:0]        r_word_cnt;
  logic                   r_full;
  logic                   r_cpu_rst_n;
  logic                   w_rise;
  logic                   w_bit;
  logic                   w_last_bit;
  logic                   w_start;

  assign w_rise     = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_bit      = r_dat_sync[SYNC_STAGES-1];
  assign w_last_bit = (r_bit_cnt == BCNT_W'(DATA_W - 1));

  // Synchronise the serial pins and remember the previous synced clock level.
  always_ff @(posedge clk) begin
    // NOTE: the synchroniser and shift register are ordinary flops, not a memory
    // array, so they are cleared on reset like every other piece of state.
    if (!rst_n) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments so each flop samples the previous
      // stage's old value. Blocking assignments would collapse the chain.
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ser_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default before the case statement, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_next  = r_state;
    w_start = 1'b0;
    imem_we = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load_en) begin
          w_start = 1'b1;
          w_next  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (!load_en)                           w_next = S_DONE;
        else if (w_rise && w_last_bit && !r_full) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
        w_next  = load_en ? S_SHIFT : S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (load_en) begin
          w_start = 1'b1;
          w_next  = S_SHIFT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: shift register, bit and word counters, full flag, core reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_full      <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_next == S_IDLE) || (w_next == S_DONE);
      // The shift register keeps shifting in the WRITE cycle. The word is already
      // presented on imem_wdata, so a bit arriving then becomes bit 0 of the next word.
      if (w_rise) r_shift <= {r_shift[DATA_W-2:0], w_bit};
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_full     <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        if (w_rise) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BCNT_W'(1);
      end else if (r_state == S_WRITE) begin
        r_bit_cnt  <= w_rise ? BCNT_W'(1) : '0;
        r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
        if (&r_word_cnt[ADDR_W-1:0]) r_full <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running XOR of every written word. It is cleared at load start and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_checksum <= '0;
    else if (w_start)            r_checksum <= '0;
    else if (r_state == S_WRITE) r_checksum <= r_checksum ^ r_shift;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign imem_addr  = r_word_cnt[ADDR_W-1:0];
  assign imem_wdata = r_shift;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign full       = r_full;
  assign word_cnt   = r_word_cnt;

endmodule
